// File: rtl/fade_pkg.sv
// Shared types and the phase-to-duty decode for the RGB hue-wheel fade.
package fade_pkg;

  // Wide enough for any practical PWM_INTERVAL; callers truncate to their own width.
  localparam int unsigned DUTY_W_MAX = 16;

  typedef logic [DUTY_W_MAX-1:0] duty_word_t;

  // Six hue-wheel phases; each names the channel that ramps during it.
  typedef enum logic [2:0] {
    PH_RG_UP = 3'd0,
    PH_R_DN  = 3'd1,
    PH_B_UP  = 3'd2,
    PH_G_DN  = 3'd3,
    PH_R_UP  = 3'd4,
    PH_B_DN  = 3'd5
  } phase_t;

  typedef struct packed {
    duty_word_t r;
    duty_word_t g;
    duty_word_t b;
  } rgb_duty_t;

  // Successor phase on the wheel; PH_B_DN wraps back to PH_RG_UP.
  function automatic phase_t phase_next(phase_t ph);
    phase_t nx;
    if (ph == PH_B_DN) nx = PH_RG_UP;
    else               nx = phase_t'(3'(ph) + 3'd1);
    return nx;
  endfunction

  // One channel ramps with r; the other two sit at full or off.
  function automatic rgb_duty_t duty_decode(phase_t ph, duty_word_t r, duty_word_t max);
    rgb_duty_t d;
    d = '0;
    case (ph)
      PH_RG_UP: begin d.r = max;     d.g = r;       d.b = '0;      end
      PH_R_DN:  begin d.r = max - r; d.g = max;     d.b = '0;      end
      PH_B_UP:  begin d.r = '0;      d.g = max;     d.b = r;       end
      PH_G_DN:  begin d.r = '0;      d.g = max - r; d.b = max;     end
      PH_R_UP:  begin d.r = r;       d.g = '0;      d.b = max;     end
      PH_B_DN:  begin d.r = max;     d.g = '0;      d.b = max - r; end
      default:  begin d.r = max;     d.g = '0;      d.b = '0;      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rgb_fade_sequencer_if.sv
// Run-enable and duty bus between the fade sequencer and the PWM generators.
//   en          : run enable (low freezes the sequence)
//   duty_r/g/b  : per-channel duty, 0..MAX
//   phase       : current hue-wheel phase, 0..5
//   cycle_done  : one-clock pulse on the phase 5 -> 0 wrap
interface rgb_fade_sequencer_if #(
  parameter int unsigned DUTY_W = 11
);
  logic              en;
  logic [DUTY_W-1:0] duty_r;
  logic [DUTY_W-1:0] duty_g;
  logic [DUTY_W-1:0] duty_b;
  logic [2:0]        phase;
  logic              cycle_done;

  modport master (
    input  en,
    output duty_r, duty_g, duty_b, phase, cycle_done
  );

  modport slave (
    output en,
    input  duty_r, duty_g, duty_b, phase, cycle_done
  );
endinterface

// File: rtl/rgb_fade_sequencer_step_timer.sv
// Free-running step timer: pulses tick once every STEP_CYCLES enabled clocks.
//   clk  : clock
//   rst  : synchronous active-high reset
//   en   : count enable; low clears the count so partial steps are discarded
//   tick : combinational, high while the count is on its last value and en=1
module step_timer #(
  parameter int unsigned STEP_CYCLES = 200000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] tcnt;

  // Count 0..LAST and wrap; a dropped enable restarts the step from zero.
  always_ff @(posedge clk) begin
    if (rst)               tcnt <= '0;
    else if (!en)          tcnt <= '0;
    else if (tcnt == LAST) tcnt <= '0;
    else                   tcnt <= tcnt + CNT_W'(1);
  end

  assign tick = en && (tcnt == LAST);

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Six-phase hue-wheel fade driving three PWM duty inputs.
//   clk  : system clock
//   rst  : synchronous active-high reset, overrides everything
//   bus  : master side of rgb_fade_sequencer_if (en in; duties, phase, cycle_done out)
module rgb_fade_sequencer
  import fade_pkg::*;
#(
  parameter int unsigned PWM_INTERVAL = 1200,
  parameter int unsigned DUTY_INC     = 20,
  parameter int unsigned STEP_CYCLES  = 200000
) (
  input  logic                  clk,
  input  logic                  rst,
  rgb_fade_sequencer_if.master  bus
);

  localparam int unsigned DUTY_W = $clog2(PWM_INTERVAL);
  localparam logic [DUTY_W-1:0] MAX    = DUTY_W'(PWM_INTERVAL);
  localparam logic [DUTY_W-1:0] INC    = DUTY_W'(DUTY_INC);
  localparam logic [DUTY_W-1:0] R_LAST = DUTY_W'(PWM_INTERVAL - DUTY_INC);

  // A ramp that does not land exactly on MAX would break phase-boundary continuity.
  if (DUTY_INC == 0 || (PWM_INTERVAL % DUTY_INC) != 0) begin : g_bad_duty_inc
    $error("rgb_fade_sequencer: DUTY_INC must be nonzero and divide PWM_INTERVAL");
  end

  logic tick;

  step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_step_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .tick (tick)
  );

  phase_t            phase_q,  phase_d;
  logic [DUTY_W-1:0] r_q,      r_d;
  logic [DUTY_W-1:0] duty_r_q, duty_g_q, duty_b_q;
  logic              cycle_done_q, cycle_done_d;
  rgb_duty_t         dec;
  logic              unused_dec;

  // Next ramp/phase; outputs decode from the post-update values so they move on the tick edge.
  always_comb begin
    phase_d      = phase_q;
    r_d          = r_q;
    cycle_done_d = 1'b0;
    if (tick) begin
      if (r_q == R_LAST) begin
        r_d          = '0;
        phase_d      = phase_next(phase_q);
        cycle_done_d = (phase_q == PH_B_DN);
      end else begin
        r_d = r_q + INC;
      end
    end
    dec = duty_decode(phase_d, DUTY_W_MAX'(r_d), DUTY_W_MAX'(MAX));
  end

  // Upper decode bits are always zero at this instance's width.
  assign unused_dec = ^dec;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= PH_RG_UP;
      r_q          <= '0;
      duty_r_q     <= MAX;
      duty_g_q     <= '0;
      duty_b_q     <= '0;
      cycle_done_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      r_q          <= r_d;
      duty_r_q     <= DUTY_W'(dec.r);
      duty_g_q     <= DUTY_W'(dec.g);
      duty_b_q     <= DUTY_W'(dec.b);
      cycle_done_q <= cycle_done_d;
    end
  end

  assign bus.duty_r     = duty_r_q;
  assign bus.duty_g     = duty_g_q;
  assign bus.duty_b     = duty_b_q;
  assign bus.phase      = 3'(phase_q);
  assign bus.cycle_done = cycle_done_q;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Self-checking bench for rgb_fade_sequencer with a hue-position reference model.
module tb_rgb_fade_sequencer;

  localparam int unsigned PWM_INTERVAL = 12;
  localparam int unsigned DUTY_INC     = 4;
  localparam int unsigned STEP_CYCLES  = 5;
  localparam int unsigned DW           = $clog2(PWM_INTERVAL);
  localparam int          MAXV         = 12;
  localparam int          STEPS_PER_PH = 3;
  localparam int          STEPS_CYCLE  = 18;

  logic clk = 1'b0;
  logic rst;

  rgb_fade_sequencer_if #(.DUTY_W(DW)) bus ();

  rgb_fade_sequencer #(
    .PWM_INTERVAL (PWM_INTERVAL),
    .DUTY_INC     (DUTY_INC),
    .STEP_CYCLES  (STEP_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: timer count and step index k along the wheel (hue position = k*DUTY_INC).
  int m_tc = 0;
  int m_k  = 0;
  bit m_cd = 1'b0;
  bit m_was_rst = 1'b1;
  bit chk_on = 1'b0;
  bit prev_valid = 1'b0;
  int prev_r, prev_g, prev_b;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Channel values as piecewise functions of hue position x in 0..6*MAX-1.
  function automatic int hue_r(int x);
    if (x < MAXV)          return MAXV;
    else if (x < 2*MAXV)   return 2*MAXV - x;
    else if (x < 4*MAXV)   return 0;
    else if (x < 5*MAXV)   return x - 4*MAXV;
    else                   return MAXV;
  endfunction

  function automatic int hue_g(int x);
    if (x < MAXV)          return x;
    else if (x < 3*MAXV)   return MAXV;
    else if (x < 4*MAXV)   return 4*MAXV - x;
    else                   return 0;
  endfunction

  function automatic int hue_b(int x);
    if (x < 2*MAXV)        return 0;
    else if (x < 3*MAXV)   return x - 2*MAXV;
    else if (x < 5*MAXV)   return MAXV;
    else                   return 6*MAXV - x;
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  always @(posedge clk) begin
    m_was_rst = rst;
    if (rst) begin
      m_tc = 0;
      m_k  = 0;
      m_cd = 1'b0;
    end else begin
      m_cd = 1'b0;
      if (!bus.en) begin
        m_tc = 0;
      end else if (m_tc == STEP_CYCLES - 1) begin
        m_tc = 0;
        if (m_k == STEPS_CYCLE - 1) begin
          m_k  = 0;
          m_cd = 1'b1;
        end else begin
          m_k = m_k + 1;
        end
      end else begin
        m_tc = m_tc + 1;
      end
    end
  end

  // Per-cycle comparison against the model, plus the slew bound between cycles.
  always @(negedge clk) begin
    if (chk_on) begin
      check("phase",      int'(bus.phase),      m_k / STEPS_PER_PH);
      check("duty_r",     int'(bus.duty_r),     hue_r(m_k * int'(DUTY_INC)));
      check("duty_g",     int'(bus.duty_g),     hue_g(m_k * int'(DUTY_INC)));
      check("duty_b",     int'(bus.duty_b),     hue_b(m_k * int'(DUTY_INC)));
      check("cycle_done", int'(bus.cycle_done), int'(m_cd));
      if (prev_valid && !m_was_rst) begin
        check("slew_r", int'(iabs(int'(bus.duty_r) - prev_r) <= int'(DUTY_INC)), 1);
        check("slew_g", int'(iabs(int'(bus.duty_g) - prev_g) <= int'(DUTY_INC)), 1);
        check("slew_b", int'(iabs(int'(bus.duty_b) - prev_b) <= int'(DUTY_INC)), 1);
      end
      prev_r = int'(bus.duty_r);
      prev_g = int'(bus.duty_g);
      prev_b = int'(bus.duty_b);
      prev_valid = 1'b1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int cd_cnt;
    bit found;
    rst    = 1'b1;
    bus.en = 1'b0;
    @(negedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    bus.en = 1'b1;

    // Reset values.
    check("rst_r",     int'(bus.duty_r), 12);
    check("rst_g",     int'(bus.duty_g), 0);
    check("rst_b",     int'(bus.duty_b), 0);
    check("rst_phase", int'(bus.phase),  0);
    check("rst_cd",    int'(bus.cycle_done), 0);

    // First change lands on edge STEP_CYCLES after release.
    step(4);
    check("pre_first_tick_g", int'(bus.duty_g), 0);
    step(1);
    check("first_tick_g", int'(bus.duty_g), 4);

    // End of phase 0 ramp: phase 1 with R and G both full, then R falls.
    step(10);
    check("ph1_phase", int'(bus.phase),  1);
    check("ph1_r",     int'(bus.duty_r), 12);
    check("ph1_g",     int'(bus.duty_g), 12);
    step(5);
    check("ph1_r_fall", int'(bus.duty_r), 8);

    // Full cycle: a single cycle_done pulse at clock 90, duties back to (12,0,0).
    cd_cnt = 0;
    repeat (69) begin
      step(1);
      cd_cnt += int'(bus.cycle_done);
    end
    check("no_early_cycle_done", cd_cnt, 0);
    step(1);
    check("wrap_cd",    int'(bus.cycle_done), 1);
    check("wrap_phase", int'(bus.phase),  0);
    check("wrap_r",     int'(bus.duty_r), 12);
    check("wrap_g",     int'(bus.duty_g), 0);
    check("wrap_b",     int'(bus.duty_b), 0);
    step(1);
    check("wrap_cd_low", int'(bus.cycle_done), 0);

    // Drop en with tcnt=3 for 7 clocks; next change exactly 5 clocks after reassert.
    step(2);
    bus.en = 1'b0;
    step(7);
    check("gated_g", int'(bus.duty_g), 0);
    bus.en = 1'b1;
    step(4);
    check("reen_pre_g", int'(bus.duty_g), 0);
    step(1);
    check("reen_latency_g", int'(bus.duty_g), 4);

    // Reset coinciding with a tick during phase 3.
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (m_tc == STEP_CYCLES - 1 && m_k / STEPS_PER_PH == 3) begin
        found = 1'b1;
        break;
      end
    end
    check("found_ph3_tick", int'(found), 1);
    rst = 1'b1;
    step(1);
    check("midrst_r",     int'(bus.duty_r), 12);
    check("midrst_g",     int'(bus.duty_g), 0);
    check("midrst_b",     int'(bus.duty_b), 0);
    check("midrst_phase", int'(bus.phase),  0);
    check("midrst_cd",    int'(bus.cycle_done), 0);
    rst = 1'b0;

    // Randomized enable gaps and occasional resets, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      bus.en = ($urandom_range(0, 9) != 0);
      rst    = ($urandom_range(0, 299) == 0);
      step(1);
    end
    rst    = 1'b0;
    bus.en = 1'b1;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
